// File: rtl/lightboard_pkg.sv
// Shared types and constants for the lightboard pen-tracking pipeline.
package lightboard_pkg;

  localparam int H_RES = 1280;
  localparam int V_RES = 720;
  localparam int X_W   = 11;
  localparam int Y_W   = 10;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } point_t;

  typedef enum logic [1:0] {IDLE, SETUP, DRAW} draw_state_t;

  function automatic logic [11:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/stroke_drawer_if.sv
// Point input and pixel output bundle of stroke_drawer; slave is the drawer side.
interface stroke_drawer_if;
  import lightboard_pkg::*;

  logic [X_W-1:0] x_com_in;
  logic [Y_W-1:0] y_com_in;
  logic           valid_com_in;
  logic           clear_in;
  logic [X_W-1:0] pix_x_out;
  logic [Y_W-1:0] pix_y_out;
  logic           pix_valid_out;
  logic           pix_ready_in;
  logic           busy_out;
  logic           drop_out;

  modport slave (
    input  x_com_in, y_com_in, valid_com_in, clear_in, pix_ready_in,
    output pix_x_out, pix_y_out, pix_valid_out, busy_out, drop_out
  );

  modport master (
    output x_com_in, y_com_in, valid_com_in, clear_in, pix_ready_in,
    input  pix_x_out, pix_y_out, pix_valid_out, busy_out, drop_out
  );

endinterface

// File: rtl/line_stepper.sv
// Bresenham core: loads start/end on start, then walks the segment one pixel per accepted beat.
module line_stepper
  import lightboard_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  point_t p0,
  input  point_t p1,
  output point_t pix,
  output logic   pix_valid,
  input  logic   pix_ready,
  output logic   done
);

  typedef logic signed [12:0] s13_t;

  s13_t x, y, tx, ty, dx, dy, sx, sy, err;
  s13_t x0, y0, x1, y1, ddx, ddy, adx, ady, e2, err_nx, x_nx, y_nx;
  logic at_end;

  always_comb begin
    x0  = $signed({2'b00, p0.x});
    y0  = $signed({3'b000, p0.y});
    x1  = $signed({2'b00, p1.x});
    y1  = $signed({3'b000, p1.y});
    ddx = x1 - x0;
    ddy = y1 - y0;
    adx = ddx[12] ? -ddx : ddx;
    ady = ddy[12] ? -ddy : ddy;
    // Both axis decisions look at the pre-step error term.
    e2     = err <<< 1;
    err_nx = err;
    x_nx   = x;
    y_nx   = y;
    if (e2 >= dy) begin
      err_nx = err_nx + dy;
      x_nx   = x + sx;
    end
    if (e2 <= dx) begin
      err_nx = err_nx + dx;
      y_nx   = y + sy;
    end
  end

  assign at_end = (x == tx) && (y == ty);
  assign done   = pix_valid && pix_ready && at_end;
  assign pix.x  = x[10:0];
  assign pix.y  = y[9:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      tx        <= '0;
      ty        <= '0;
      dx        <= '0;
      dy        <= '0;
      sx        <= '0;
      sy        <= '0;
      err       <= '0;
      pix_valid <= 1'b0;
    end else if (start) begin
      x         <= x0;
      y         <= y0;
      tx        <= x1;
      ty        <= y1;
      dx        <= adx;
      dy        <= -ady;
      sx        <= ddx[12] ? -13'sd1 : 13'sd1;
      sy        <= ddy[12] ? -13'sd1 : 13'sd1;
      err       <= adx - ady;
      pix_valid <= 1'b1;
    end else if (pix_valid && pix_ready) begin
      if (at_end) begin
        pix_valid <= 1'b0;
      end else begin
        x   <= x_nx;
        y   <= y_nx;
        err <= err_nx;
      end
    end
  end

endmodule

// File: rtl/stroke_drawer.sv
// Joins successive pen points into pixel strokes; owns prev point, range/jump tests and drops.
//   state | meaning
//   IDLE  | waiting for an in-range point strobe
//   SETUP | stepper loads start/target this cycle
//   DRAW  | stepper streams pixels until target accepted
module stroke_drawer
  import lightboard_pkg::*;
#(
  parameter int H_RES    = lightboard_pkg::H_RES,
  parameter int V_RES    = lightboard_pkg::V_RES,
  parameter int MAX_JUMP = 64
) (
  input logic            clk_in,
  input logic            rst_in,
  stroke_drawer_if.slave bus
);

  draw_state_t state;
  point_t      prev, start_pt, target, incoming, pix;
  logic        has_prev, clear_pend, busy, drop;
  logic        in_range, near, hp_eff, pix_valid, done;
  logic [11:0] jx, jy;

  assign incoming.x = bus.x_com_in;
  assign incoming.y = bus.y_com_in;
  assign in_range   = (int'(bus.x_com_in) < H_RES) && (int'(bus.y_com_in) < V_RES);
  assign jx         = abs_diff({1'b0, bus.x_com_in}, {1'b0, prev.x});
  assign jy         = abs_diff({2'b00, bus.y_com_in}, {2'b00, prev.y});
  assign near       = (int'(jx) <= MAX_JUMP) && (int'(jy) <= MAX_JUMP);
  // A clear in the same cycle as the strobe wins, so the point starts a fresh stroke.
  assign hp_eff     = has_prev && !bus.clear_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      busy       <= 1'b0;
      drop       <= 1'b0;
      has_prev   <= 1'b0;
      clear_pend <= 1'b0;
      prev       <= '0;
      start_pt   <= '0;
      target     <= '0;
    end else begin
      drop <= bus.valid_com_in && ((state != IDLE) || !in_range);
      if (bus.clear_in) has_prev <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.valid_com_in && in_range) begin
            target     <= incoming;
            start_pt   <= (hp_eff && near) ? prev : incoming;
            clear_pend <= 1'b0;
            busy       <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          if (bus.clear_in) clear_pend <= 1'b1;
          state <= DRAW;
        end
        DRAW: begin
          if (bus.clear_in) clear_pend <= 1'b1;
          if (done) begin
            busy  <= 1'b0;
            state <= IDLE;
            // A pen lift seen during the segment keeps its endpoint out of prev.
            if (!clear_pend && !bus.clear_in) begin
              has_prev <= 1'b1;
              prev     <= target;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  line_stepper u_stepper (
    .clk       (clk_in),
    .rst       (rst_in),
    .start     (state == SETUP),
    .p0        (start_pt),
    .p1        (target),
    .pix       (pix),
    .pix_valid (pix_valid),
    .pix_ready (bus.pix_ready_in),
    .done      (done)
  );

  assign bus.pix_x_out     = pix.x;
  assign bus.pix_y_out     = pix.y;
  assign bus.pix_valid_out = pix_valid;
  assign bus.busy_out      = busy;
  assign bus.drop_out      = drop;

endmodule

// File: tb/tb_stroke_drawer.sv
// Directed and randomized checks of stroke_drawer against a point-list reference model.
module tb_stroke_drawer;
  import lightboard_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  stroke_drawer_if bus ();

  stroke_drawer #(.H_RES(1280), .V_RES(720), .MAX_JUMP(64)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  bit m_has_prev = 1'b0;
  int m_px = 0;
  int m_py = 0;
  int exp_x[$];
  int exp_y[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Expected pixel list of the segment from (x0,y0) to (x1,y1), endpoints inclusive.
  task automatic build_line(input int x0, input int y0, input int x1, input int y1);
    int dx, dy, sx, sy, err, e2, x, y;
    dx = iabs(x1 - x0);
    dy = -iabs(y1 - y0);
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x = x0;
    y = y0;
    exp_x.delete();
    exp_y.delete();
    for (int i = 0; i < 4000; i++) begin
      exp_x.push_back(x);
      exp_y.push_back(y);
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // Entered and left at #1 after a rising edge; strobes immediately.
  // mode: 0 ready always high, 1 ready 1010..., 2 random ready.
  task automatic segment(input int tx, input int ty, input bit clr, input int mode,
                         input bit mid_strobe, input bit mid_clear);
    bit in_rng, hp, held, pend_drop, cleared_mid, rdy, first;
    int k, n, lx, ly;
    in_rng = (tx < 1280) && (ty < 720);
    hp = m_has_prev && !clr;
    if (clr) m_has_prev = 1'b0;
    bus.x_com_in = 11'(tx);
    bus.y_com_in = 10'(ty);
    bus.valid_com_in = 1'b1;
    bus.clear_in = clr;
    @(posedge clk_in); #1;
    bus.valid_com_in = 1'b0;
    bus.clear_in = 1'b0;
    if (!in_rng) begin
      check("drop_pulse", bus.drop_out, 1);
      check("drop_not_busy", bus.busy_out, 0);
      @(posedge clk_in); #1;
      check("drop_one_cycle", bus.drop_out, 0);
      check("drop_no_pixel", bus.pix_valid_out, 0);
      return;
    end
    if (hp && iabs(tx - m_px) <= 64 && iabs(ty - m_py) <= 64) build_line(m_px, m_py, tx, ty);
    else build_line(tx, ty, tx, ty);
    n = exp_x.size();
    check("busy_setup", bus.busy_out, 1);
    check("valid_setup", bus.pix_valid_out, 0);
    held = 0; pend_drop = 0; cleared_mid = 0; first = 1; k = 0; lx = 0; ly = 0;
    while (exp_x.size() > 0) begin
      @(posedge clk_in); #1;
      bus.valid_com_in = 1'b0;
      bus.clear_in = 1'b0;
      if (pend_drop) begin
        check("drop_mid_draw", bus.drop_out, 1);
        pend_drop = 0;
      end
      if (k > 1000) begin
        check("timeout", 0, 1);
        return;
      end
      if (first) begin
        check("first_pixel_latency", bus.pix_valid_out, 1);
        first = 0;
      end
      if (held) begin
        check("hold_valid", bus.pix_valid_out, 1);
        check("hold_x", bus.pix_x_out, lx);
        check("hold_y", bus.pix_y_out, ly);
      end
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 2 == 0) : 1'($urandom_range(0, 1));
      k++;
      bus.pix_ready_in = rdy;
      if (mid_strobe && k == 2 && bus.pix_valid_out) begin
        bus.x_com_in = 11'($urandom_range(0, 1279));
        bus.y_com_in = 10'($urandom_range(0, 719));
        bus.valid_com_in = 1'b1;
        pend_drop = 1;
      end
      if (mid_clear && k == 3 && bus.pix_valid_out) begin
        bus.clear_in = 1'b1;
        cleared_mid = 1;
      end
      if (bus.pix_valid_out && rdy) begin
        check("pix_x", bus.pix_x_out, exp_x.pop_front());
        check("pix_y", bus.pix_y_out, exp_y.pop_front());
        held = 0;
      end else begin
        held = bus.pix_valid_out;
        lx = int'(bus.pix_x_out);
        ly = int'(bus.pix_y_out);
      end
    end
    if (mode == 0) check("throughput_cycles", k, n);
    @(posedge clk_in); #1;
    bus.valid_com_in = 1'b0;
    bus.clear_in = 1'b0;
    if (pend_drop) check("drop_mid_draw", bus.drop_out, 1);
    check("end_valid_low", bus.pix_valid_out, 0);
    check("end_idle", bus.busy_out, 0);
    if (cleared_mid) m_has_prev = 1'b0;
    else begin
      m_has_prev = 1'b1;
      m_px = tx;
      m_py = ty;
    end
  endtask

  initial begin
    int tx, ty;
    rst_in = 1'b1;
    bus.x_com_in = '0;
    bus.y_com_in = '0;
    bus.valid_com_in = 1'b0;
    bus.clear_in = 1'b0;
    bus.pix_ready_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_pix_x", bus.pix_x_out, 0);
    check("rst_pix_y", bus.pix_y_out, 0);
    check("rst_valid", bus.pix_valid_out, 0);
    check("rst_busy", bus.busy_out, 0);
    check("rst_drop", bus.drop_out, 0);
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    segment(100, 50, 0, 0, 0, 0);
    segment(105, 50, 0, 0, 0, 0);
    segment(10, 10, 1, 0, 0, 0);
    segment(13, 17, 0, 1, 0, 0);
    segment(0, 0, 1, 0, 0, 0);
    segment(200, 0, 0, 0, 0, 0);
    segment(201, 0, 1, 0, 0, 0);
    segment(1280, 5, 0, 0, 0, 0);
    segment(240, 30, 0, 0, 1, 0);
    segment(250, 40, 0, 1, 0, 1);
    segment(255, 42, 0, 0, 0, 0);

    // Reset on the third pixel of a 20-pixel segment.
    segment(300, 300, 1, 0, 0, 0);
    build_line(300, 300, 319, 305);
    check("rst_seg_len", exp_x.size(), 20);
    bus.x_com_in = 11'd319;
    bus.y_com_in = 10'd305;
    bus.valid_com_in = 1'b1;
    bus.pix_ready_in = 1'b1;
    @(posedge clk_in); #1;
    bus.valid_com_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_third_valid", bus.pix_valid_out, 1);
    check("rst_third_x", bus.pix_x_out, exp_x[2]);
    check("rst_third_y", bus.pix_y_out, exp_y[2]);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    check("midrst_pix_x", bus.pix_x_out, 0);
    check("midrst_pix_y", bus.pix_y_out, 0);
    check("midrst_valid", bus.pix_valid_out, 0);
    check("midrst_busy", bus.busy_out, 0);
    check("midrst_drop", bus.drop_out, 0);
    rst_in = 1'b0;
    m_has_prev = 1'b0;
    @(posedge clk_in); #1;
    segment(302, 300, 0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      tx = m_px + int'($urandom_range(0, 160)) - 80;
      ty = m_py + int'($urandom_range(0, 160)) - 80;
      if (tx < 0) tx = 0;
      if (ty < 0) ty = 0;
      if (tx > 1279) tx = 1279;
      if (ty > 719) ty = 719;
      if ($urandom_range(0, 9) == 0) tx = 1280 + int'($urandom_range(0, 700));
      if ($urandom_range(0, 9) == 0) ty = 720 + int'($urandom_range(0, 300));
      segment(tx, ty, ($urandom_range(0, 7) == 0), 2,
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stroke_drawer.md
# stroke_drawer

Turns the once-per-frame centre-of-mass point of the tracked pen into a continuous stroke of pixel writes. It remembers the previous accepted point and, for each new point, emits every pixel on the straight segment between them (Bresenham), one pixel per handshake, to the canvas frame-buffer writer. It sits directly downstream of the centre-of-mass stage (consumes `x_com`/`y_com`/`valid_com`) and upstream of the canvas BRAM write port.

## Interface
Parameters:
- `H_RES`, 1280 — canvas width; incoming x ≥ H_RES is rejected.
- `V_RES`, 720 — canvas height; incoming y ≥ V_RES is rejected.
- `MAX_JUMP`, 64 — Chebyshev distance above which a new point starts a new stroke instead of being joined.

Ports:
- `clk_in`  in  1  — system clock; the only clock.
- `rst_in`  in  1  — reset, synchronous, active-high.
- `x_com_in`  in  11  — centre-of-mass x.
- `y_com_in`  in  10  — centre-of-mass y.
- `valid_com_in`  in  1  — single-cycle strobe, point valid.
- `clear_in`  in  1  — pen lifted: forget the previous point.
- `pix_x_out`  out  11  — pixel x to write.
- `pix_y_out`  out  10  — pixel y to write.
- `pix_valid_out`  out  1  — pixel valid.
- `pix_ready_in`  in  1  — writer accepts the pixel.
- `busy_out`  out  1  — high whenever state ≠ IDLE.
- `drop_out`  out  1  — one-cycle pulse: a valid point was discarded.

## Operation
- State register `has_prev`, plus `prev_x`/`prev_y`.
- States: IDLE → SETUP → DRAW → IDLE.
- **IDLE:** on `valid_com_in` with in-range coordinates, latch the point as the target. Out-of-range points pulse `drop_out` and stay in IDLE.
- **Start point selection:** if `!has_prev`, or `max(|dx|,|dy|) > MAX_JUMP`, start = target, which gives a single pixel. Otherwise start = prev.
- **SETUP** (one cycle):
  - dx = |x1−x0|, dy = −|y1−y0|.
  - sx/sy = ±1.
  - err = dx+dy.
  - All signed, 13 bits.
- **DRAW:**
  - Present (x,y). On `pix_valid_out && pix_ready_in`:
    - If (x,y) == target: set prev = target, `has_prev`=1, go to IDLE.
    - Else with e2 = 2·err: if e2 ≥ dy then err += dy, x += sx; if e2 ≤ dx then err += dx, y += sy. Both updates use the old err.
  - Pixel count = max(|dx|,|dy|)+1. Endpoints are inclusive, so the shared endpoint of consecutive segments is written twice; this is allowed.
- **`valid_com_in` while not IDLE:** the point is discarded and `drop_out` pulses. There is no queue.
- **`clear_in`:**
  - Clears `has_prev` the next cycle.
  - If asserted during DRAW, the current segment finishes, but the target is not stored as prev.
  - `clear_in` and `valid_com_in` in the same IDLE cycle: clear applies first, and the point is drawn as a single pixel.
- **Reset mid-operation:** abort the segment, go to IDLE, clear `has_prev`. Outputs return to their reset values the cycle after `rst_in` is sampled high.

## Timing
- **Reset values:** `pix_x_out`=0, `pix_y_out`=0, `pix_valid_out`=0, `busy_out`=0, `drop_out`=0, `has_prev`=0, state IDLE.
- **Latency:** strobe at cycle N; `busy_out` rises at N+1 (SETUP); first pixel valid at N+2.
- **Throughput:** one pixel per cycle while `pix_ready_in`=1.
- **Handshake rules:**
  - `pix_x_out`/`pix_y_out` stay stable and `pix_valid_out` stays high until accepted.
  - `pix_valid_out` never depends combinationally on `pix_ready_in`.
- **Return to idle:** after the last pixel is accepted, `pix_valid_out` drops and state is IDLE the next cycle. A new strobe is accepted in that cycle.
- All outputs are registered.

## Structure
- Shared package `lightboard_pkg` holds:
  - `H_RES`, `V_RES` defaults.
  - Coordinate widths (`X_W`=11, `Y_W`=10).
  - `typedef struct packed {logic [10:0] x; logic [9:0] y;} point_t`.
  - The state enum `draw_state_t {IDLE, SETUP, DRAW}`.
- One natural sub-module, `line_stepper`, is the Bresenham core. It takes start/end with a start strobe and produces the valid/ready pixel stream plus a done signal. `stroke_drawer` owns the prev-point logic, range checks, jump test and drop logic.

## Test plan
- **First point:** after reset, strobe (100,50) with ready=1 → exactly one pixel (100,50) at cycle N+2; IDLE at N+3; `has_prev`=1.
- **Horizontal segment:** prev (100,50), strobe (105,50) → pixels x=100..105, y=50, six beats, consecutive cycles.
- **Diagonal segment with backpressure:** prev (10,10), strobe (13,17), ready toggling 1010… →
  - 8 pixels, Bresenham-exact: (10,10),(10,11),(11,12),(11,13),(12,14),(12,15),(13,16),(13,17).
  - Outputs are held stable on every ready=0 cycle.
- **Jump and clear:**
  - prev (0,0), strobe (200,0) → single pixel (200,0).
  - Then `clear_in`, strobe (201,0) → single pixel (201,0).
- **Drops:**
  - Strobe (1280,5) → `drop_out` pulse, no pixels.
  - Strobe during DRAW → `drop_out` pulse; the current segment is unaffected.
- **Reset mid-draw:** assert `rst_in` on the 3rd pixel of a 20-pixel segment → next cycle all outputs are 0; a following strobe draws a single pixel.
